// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and helpers for the instruction fetch unit.
//   OPC_JAL       - RV32 JAL major opcode
//   j_imm()       - sign-extended J-type immediate
//   fetch_entry_t - {instruction, pc} pair buffered ahead of the IFQ
package fetch_pkg;

  localparam logic [6:0] OPC_JAL = 7'b1101111;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  // J-type immediate: imm[20|10:1|11|19:12] scattered over instr[31:12]
  function automatic logic [31:0] j_imm(input logic [31:0] instr);
    return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_resp_buf.sv
// fetch_resp_buf: DEPTH-entry FIFO of fetch_entry_t, first-word fall-through.
//   clk, rst           - clock, asynchronous active-high reset
//   push, push_entry   - write port
//   pop                - remove head (caller guarantees non-empty)
//   clear              - drop all entries; wins over push/pop
//   empty, count, head - status and head entry
module fetch_resp_buf
  import fetch_pkg::*;
#(
  parameter int unsigned  DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  fetch_entry_t       push_entry,
  input  logic               pop,
  input  logic               clear,
  output logic               empty,
  output logic [CNT_W-1:0]   count,
  output fetch_entry_t       head
);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Pointer/count update
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential-PC instruction fetch feeding the IFQ write port.
//   clk, rst                         - clock, asynchronous active-high reset
//   fetch_en                         - allow new memory requests
//   redirect_valid, redirect_pc      - restart fetch at redirect_pc (also IFQ flush)
//   imem_req_valid/ready/addr        - word request to instruction memory
//   imem_resp_valid/data             - in-order responses, latency >= 1
//   ifq_wr_en/instruction/pc, ifq_full - IFQ push port
// Optional: `define FETCH_JAL_PREDICT_EN to redirect on pushed JAL instructions.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        ifq_wr_en,
  output logic [31:0] ifq_instruction,
  output logic [31:0] ifq_pc,
  input  logic        ifq_full
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic             buf_empty;
  logic [CNT_W-1:0] buf_count;
  fetch_entry_t     buf_head;
  fetch_entry_t     buf_push_entry;

  logic             credit;
  logic             req_hs;
  logic             jal_hit;
  logic [31:0]      jal_target;
  logic             flush;
  logic [31:0]      flush_pc;
  logic             resp_keep;

  // Request/push handshakes and redirect selection
  always_comb begin
    credit          = ({1'b0, out_q} + {1'b0, buf_count}) < (CNT_W + 1)'(MAX_OUTSTANDING);
    imem_req_valid  = fetch_en & credit & ~redirect_valid;
    imem_req_addr   = {pc_q[31:2], 2'b00};
    req_hs          = imem_req_valid & imem_req_ready;
    ifq_wr_en       = ~buf_empty & ~ifq_full & ~redirect_valid;
    ifq_instruction = buf_head.instr;
    ifq_pc          = buf_head.pc;
`ifdef FETCH_JAL_PREDICT_EN
    jal_hit         = ifq_wr_en & (buf_head.instr[6:0] == OPC_JAL);
    jal_target      = buf_head.pc + j_imm(buf_head.instr);
`else
    jal_hit         = 1'b0;
    jal_target      = '0;
`endif
    flush           = redirect_valid | jal_hit;
    flush_pc        = redirect_valid ? {redirect_pc[31:2], 2'b00} : {jal_target[31:2], 2'b00};
    // A response landing in a flush cycle is already stale
    resp_keep       = imem_resp_valid & (drop_q == '0) & ~flush;
    buf_push_entry  = '{instr: imem_resp_data, pc: resp_pc_q};
  end

  // Next-state for PCs and in-flight accounting
  always_comb begin
    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    out_d     = out_q + CNT_W'(req_hs) - CNT_W'(imem_resp_valid);
    drop_d    = drop_q;
    if (flush) begin
      pc_d      = flush_pc;
      resp_pc_d = flush_pc;
      // drop is a subset of outstanding: everything still in flight is now stale
      drop_d    = out_d;
    end else begin
      if (req_hs) pc_d = pc_q + 32'd4;
      if (resp_keep) resp_pc_d = resp_pc_q + 32'd4;
      if (imem_resp_valid && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      out_q     <= '0;
      drop_q    <= '0;
    end else begin
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      out_q     <= out_d;
      drop_q    <= drop_d;
    end
  end

  fetch_resp_buf #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_resp_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (resp_keep),
    .push_entry (buf_push_entry),
    .pop        (ifq_wr_en),
    .clear      (flush),
    .empty      (buf_empty),
    .count      (buf_count),
    .head       (buf_head)
  );

endmodule
